alu_cmd_sequencer: RTL and testbench

Command-side initiator for the 32-bit ALU datapath. It accepts operation commands over a valid/ready handshake, drives registered operands and opcode into the ALU, waits a configurable settle time, then captures result and flags and returns them over a valid/ready response handshake. It replaces the manual per-register clock strobes and 2-bit operand selectors with a single-clock, bus-driven front end that the test controller or a future microsequencer drives.

---
 rtl/alu_cmd_sequencer.sv | 128 ++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command-side front end for the 32-bit ALU datapath.
// It accepts one command at a time and registers the operands and opcode
// into the ALU. After a settle delay it captures the ALU result and flags
// and returns them through a valid/ready response channel.
// Optional feature macro: ALU_SEQ_OPCHECK_EN. When it is defined, unsupported
// opcodes are answered immediately with rsp_err=1 and are never issued.
module alu_cmd_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic        cmd_chain,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_f,
  input  logic [3:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic        busy
);

  localparam int DATA_W = 32;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]        state;
  logic [3:0]        settle_cnt;
  logic [DATA_W-1:0] last_result;
  logic              op_ok;

  // Operand A is either taken from the command or chained from the last result.
  function automatic logic [DATA_W-1:0] sel_a(input logic chain,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] last);
    return chain ? last : a;
  endfunction

`ifdef ALU_SEQ_OPCHECK_EN
  logic err_q;

  // The ALU implements opcodes 0000-1000 and 1101; everything else is rejected.
  assign op_ok = (cmd_op <= 4'b1000) || (cmd_op == 4'b1101);
  assign rsp_err = err_q;

  // The error flag is latched at accept and stays stable through the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == S_IDLE && cmd_valid) begin
      err_q <= ~op_ok;
    end
  end
`else
  assign op_ok   = 1'b1;
  assign rsp_err = 1'b0;
`endif

  // Outside reset, the sequencer is ready only when it is idle.
  assign cmd_ready = (state == S_IDLE) && !rst;
  assign busy      = (state != S_IDLE);

  // Main sequencer state machine: issue, settle, capture and respond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      settle_cnt  <= 4'd0;
      last_result <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= 4'b0000;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_flags   <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (op_ok) begin
              alu_a      <= sel_a(cmd_chain, cmd_a, last_result);
              alu_b      <= cmd_b;
              alu_op     <= cmd_op;
              settle_cnt <= 4'(SETTLE_CYCLES - 1);
              state      <= S_SETTLE;
            end else begin
              // A rejected opcode skips the ALU and returns a zeroed error response.
              rsp_valid  <= 1'b1;
              rsp_result <= '0;
              rsp_flags  <= 4'b0000;
              state      <= S_RESP;
            end
          end
        end
        S_SETTLE: begin
          if (settle_cnt == 4'd0) begin
            rsp_result  <= alu_f;
            rsp_flags   <= alu_flags;
            last_result <= alu_f;
            rsp_valid   <= 1'b1;
            state       <= S_RESP;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer. It uses a behavioural ALU model and a
// scoreboard queue of expected responses.
module tb_alu_cmd_sequencer;
  localparam int SC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        cmd_chain;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_f;
  logic [3:0]  alu_flags;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] model_last = 32'd0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_f(alu_f),
    .alu_flags(alu_flags), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .busy(busy)
  );

  // Behavioural ALU; the return value is {SF,OF,CF,ZF,result}.
  function automatic logic [35:0] alu_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
    logic [32:0] w;
    logic [31:0] r;
    logic        cf;
    logic        of;
    w = 33'd0; r = 32'd0; cf = 1'b0; of = 1'b0;
    case (op)
      4'b0000: begin
        w = {1'b0, a} + {1'b0, b}; r = w[31:0]; cf = w[32];
        of = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'b1000: begin
        w = {1'b0, a} - {1'b0, b}; r = w[31:0]; cf = w[32];
        of = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'b0001: r = a << b[4:0];
      4'b0010: r = {31'd0, $signed(a) < $signed(b)};
      4'b0011: r = {31'd0, a < b};
      4'b0100: r = a ^ b;
      4'b0101: r = a >> b[4:0];
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      4'b1101: r = $signed(a) >>> b[4:0];
      default: r = ~(a ^ b);
    endcase
    return {r[31], of, cf, (r == 32'd0), r};
  endfunction

  always_comb {alu_flags, alu_f} = alu_calc(alu_a, alu_b, alu_op);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one command, wait for its acceptance, and push the expected response.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic chain);
    int          w;
    logic [35:0] m;
    logic        legal;
    exp_t        e;
    w = 0;
    @(negedge clk);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain; cmd_valid = 1'b1;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
`ifdef ALU_SEQ_OPCHECK_EN
    legal = (op <= 4'b1000) || (op == 4'b1101);
`else
    legal = 1'b1;
`endif
    if (legal) begin
      m = alu_calc(chain ? model_last : a, b, op);
      e.res = m[31:0]; e.flg = m[35:32]; e.err = 1'b0;
      model_last = m[31:0];
    end else begin
      e.res = 32'd0; e.flg = 4'd0; e.err = 1'b1;
    end
    sb.push_back(e);
    @(negedge clk);
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Wait for a response, compare it with the scoreboard, optionally hold off rsp_ready.
  task automatic get_rsp(input int hold, output logic [31:0] res, output logic [3:0] flg);
    int          lat;
    exp_t        e;
    logic [31:0] r0;
    logic [3:0]  op0;
    lat = 0;
    rsp_ready = (hold == 0);
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      e.res = 32'd0; e.flg = 4'd0; e.err = 1'b0;
    end else begin
      e = sb.pop_front();
    end
    chk("rsp_latency", 32'(lat), e.err ? 32'd0 : 32'(SC));
    chk("rsp_result", rsp_result, e.res);
    chk("rsp_flags", 32'(rsp_flags), 32'(e.flg));
    chk("rsp_err", 32'(rsp_err), 32'(e.err));
    res = rsp_result;
    flg = rsp_flags;
    if (hold > 0) begin
      r0 = rsp_result;
      op0 = alu_op;
      cmd_op = 4'b0111; cmd_a = 32'h1234; cmd_b = 32'h5678; cmd_chain = 1'b0;
      cmd_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_rsp_result", rsp_result, r0);
        chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      cmd_valid = 1'b0;
      chk("bp_alu_op_held", 32'(alu_op), 32'(op0));
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] res;
    logic [3:0]  flg;
    logic [3:0]  op_prev;
    logic [3:0]  ops[8];
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 32'd0; cmd_b = 32'd0;
    cmd_chain = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    #1 chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    // Basic add, sub to zero, and a chained shift.
    send(4'b0000, 32'd5, 32'd10, 1'b0);
    get_rsp(0, res, flg);
    chk("tp_add_15", res, 32'd15);
    chk("tp_add_flags", 32'(flg), 32'd0);
    send(4'b1000, 32'd5, 32'd5, 1'b0);
    get_rsp(0, res, flg);
    chk("tp_sub_zero", res, 32'd0);
    chk("tp_sub_zf", 32'(flg[0]), 32'd1);
    send(4'b0000, 32'd20, 32'd15, 1'b0);
    get_rsp(0, res, flg);
    chk("tp_add_35", res, 32'd35);
    send(4'b0001, 32'hDEAD, 32'd1, 1'b1);
    chk("tp_chain_alu_a", alu_a, 32'd35);
    get_rsp(0, res, flg);
    chk("tp_chain_70", res, 32'd70);

    // Assorted opcodes with random operands, plus a signed overflow.
    ops = '{4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1101, 4'b1000};
    for (int i = 0; i < 8; i++) begin
      send(ops[i], $urandom | 32'h8000_0000, $urandom, 1'b0);
      get_rsp(0, res, flg);
    end
    send(4'b0000, 32'h7FFF_FFFF, 32'd1, 1'b0);
    get_rsp(0, res, flg);
    chk("ovf_flags", 32'(flg), 32'b1100);

    // Response backpressure with a competing command.
    send(4'b0110, 32'h00F0, 32'h0F00, 1'b0);
    get_rsp(5, res, flg);

    // Unsupported opcode.
    op_prev = alu_op;
    send(4'b1010, 32'd3, 32'd4, 1'b0);
`ifdef ALU_SEQ_OPCHECK_EN
    chk("bad_op_alu_op", 32'(alu_op), 32'(op_prev));
`else
    chk("bad_op_alu_op", 32'(alu_op), 32'b1010);
`endif
    get_rsp(0, res, flg);
    send(4'b0000, 32'hFFFF, 32'd1, 1'b1);
    get_rsp(0, res, flg);

    // Reset while the command is settling.
    send(4'b0000, 32'd100, 32'd200, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_alu_b", alu_b, 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("mid_rst_rsp_result", rsp_result, 32'd0);
    sb.delete();
    model_last = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("mid_rel_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("dropped_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // After reset, chaining uses a zero last result.
    send(4'b0000, 32'hFFFF, 32'd7, 1'b1);
    get_rsp(0, res, flg);
    chk("chain_after_rst", res, 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
